// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control unit: decodes ALUOp/opcode into an ALU operation
// and stalls issue while a multi-cycle MUL occupies the ALU. Optional macro: ALUCTL_TRAP_EN.
module alu_ctrl_seq #(
   parameter int unsigned OPC_W   = 11,
   parameter int unsigned OP_W    = 4,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [OPC_W-1:0] opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OP_W-1:0]  operation,
   output logic             multicycle,
   output logic             illegal,
   output logic             busy,
   output logic             trap
);

   localparam int unsigned DEC_W     = 11;
   localparam int unsigned CNT_W     = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
   localparam int unsigned BUSY_LOAD = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
   localparam logic        MUL_STALL = (MUL_LAT > 1);

   localparam logic [DEC_W-1:0] OPC_ADD = 11'b10001011000;
   localparam logic [DEC_W-1:0] OPC_SUB = 11'b11001011000;
   localparam logic [DEC_W-1:0] OPC_AND = 11'b10001010000;
   localparam logic [DEC_W-1:0] OPC_ORR = 11'b10101010000;
   localparam logic [DEC_W-1:0] OPC_EOR = 11'b11001010000;
   localparam logic [DEC_W-1:0] OPC_LSL = 11'b11010011011;
   localparam logic [DEC_W-1:0] OPC_LSR = 11'b11010011010;
   localparam logic [DEC_W-1:0] OPC_MUL = 11'b10011011000;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ORR  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_EOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_LSL  = 4'b1000;
   localparam logic [3:0] OP_LSR  = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1100;
   localparam logic [3:0] OP_ILL  = 4'b1111;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [OP_W-1:0]   operation_q, operation_d;
   logic              multicycle_q, multicycle_d;
   logic              illegal_q, illegal_d;
   logic              busy_q, busy_d;
   logic              trap_q, trap_d;

   logic [DEC_W-1:0]  opc_key;
   logic [3:0]        dec_op;
   logic              dec_mul;
   logic              dec_ill;
   logic              in_ready_c;
   logic              accept_c;
   logic              out_hs_c;

   assign opc_key = opcode[OPC_W-1 -: DEC_W];

   // Purely combinational operation decode
   always_comb begin
      dec_op  = OP_ILL;
      dec_mul = 1'b0;
      dec_ill = 1'b0;
      if (alu_op == 2'b00) begin
         dec_op = OP_ADD;
      end else if (alu_op == 2'b01) begin
         dec_op = OP_PASS;
      end else begin
         case (opc_key)
            OPC_ADD: dec_op = OP_ADD;
            OPC_SUB: dec_op = OP_SUB;
            OPC_AND: dec_op = OP_AND;
            OPC_ORR: dec_op = OP_ORR;
            OPC_EOR: dec_op = OP_EOR;
            OPC_LSL: dec_op = OP_LSL;
            OPC_LSR: dec_op = OP_LSR;
            OPC_MUL: begin
               dec_op  = OP_MUL;
               dec_mul = 1'b1;
            end
            default: begin
               dec_op  = OP_ILL;
               dec_ill = 1'b1;
            end
         endcase
      end
   end

   // A pending MUL blocks new issue so the following op never overlaps its busy window
   assign in_ready_c = (state_q == S_IDLE) && !trap_q
                       && (!out_valid_q || out_ready)
                       && !(out_valid_q && multicycle_q && MUL_STALL);
   assign accept_c   = in_valid && in_ready_c;
   assign out_hs_c   = out_valid_q && out_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      operation_d  = operation_q;
      multicycle_d = multicycle_q;
      illegal_d    = illegal_q;
      busy_d       = busy_q;
      trap_d       = trap_q;
      case (state_q)
         S_IDLE: begin
            if (out_hs_c) begin
               out_valid_d = 1'b0;
               if (multicycle_q && MUL_STALL) begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_W'(BUSY_LOAD);
                  busy_d  = 1'b1;
               end
            end
            if (accept_c) begin
               operation_d  = OP_W'(dec_op);
               multicycle_d = dec_mul;
               illegal_d    = dec_ill;
`ifdef ALUCTL_TRAP_EN
               // Illegal ops are swallowed and halt the unit instead of reaching the ALU
               if (dec_ill) begin
                  trap_d = 1'b1;
               end else begin
                  out_valid_d = 1'b1;
               end
`else
               out_valid_d = 1'b1;
`endif
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         operation_q  <= '0;
         multicycle_q <= 1'b0;
         illegal_q    <= 1'b0;
         busy_q       <= 1'b0;
         trap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         operation_q  <= operation_d;
         multicycle_q <= multicycle_d;
         illegal_q    <= illegal_d;
         busy_q       <= busy_d;
         trap_q       <= trap_d;
      end
   end

   assign in_ready   = in_ready_c;
   assign out_valid  = out_valid_q;
   assign operation  = operation_q;
   assign multicycle = multicycle_q;
   assign illegal    = illegal_q;
   assign busy       = busy_q;
`ifdef ALUCTL_TRAP_EN
   assign trap       = trap_q;
`else
   assign trap       = 1'b0;
`endif

endmodule
